// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl: direct-mapped, read-only word cache lookup controller.
// The tag store is read on the accept edge. The registered stored tag and the
// captured request tag feed an external equality comparator during LOOKUP.
// A miss refills the line over a level req / single-cycle ack handshake.
module cache_tag_ctrl #(
   parameter int TAG_W   = 17,
   parameter int INDEX_W = 5,
   parameter int DATA_W  = 32,
   parameter int CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   input  logic [TAG_W+INDEX_W-1:0] req_addr,
   output logic                     req_ready,
   input  logic                     flush,
   output logic                     resp_valid,
   output logic [DATA_W-1:0]        resp_data,
   output logic                     resp_hit,
   output logic [TAG_W-1:0]         cmp_a,
   output logic [TAG_W-1:0]         cmp_b,
   input  logic                     cmp_eq,
   output logic                     mem_req,
   output logic [TAG_W+INDEX_W-1:0] mem_addr,
   input  logic                     mem_ack,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic [CNT_W-1:0]         hit_count,
   output logic [CNT_W-1:0]         miss_count
);

   localparam int ADDR_W = TAG_W + INDEX_W;
   localparam int LINES  = 1 << INDEX_W;

   typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;

   state_t state, state_nx;

   // line store; tag and data are deliberately left unreset
   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [DATA_W-1:0] data_mem [LINES];
   logic [LINES-1:0]  valid_q;

   logic [ADDR_W-1:0]  addr_q;
   logic               rd_valid;
   logic [DATA_W-1:0]  rd_data;

   logic [INDEX_W-1:0] req_idx, idx_q;
   logic [TAG_W-1:0]   req_tag, tag_q;
   logic               accept, hit, fill_done;

   assign req_idx = req_addr[INDEX_W-1:0];
   assign req_tag = req_addr[ADDR_W-1:INDEX_W];
   assign idx_q   = addr_q[INDEX_W-1:0];
   assign tag_q   = addr_q[ADDR_W-1:INDEX_W];

   // handshake outputs follow the state directly, so reset drops them at once
   assign resp_valid = (state == RESP);
   assign mem_req    = (state == FILL);
   assign mem_addr   = addr_q;

   // next-state and per-cycle control decode
   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      accept    = 1'b0;
      hit       = 1'b0;
      fill_done = 1'b0;
      case (state)
         IDLE: begin
            // flush wins over a simultaneous request
            req_ready = ~flush;
            accept    = req_valid & ~flush;
            if (accept) state_nx = LOOKUP;
         end
         LOOKUP: begin
            hit      = rd_valid & cmp_eq;
            state_nx = hit ? RESP : FILL;
         end
         FILL: begin
            if (mem_ack) begin
               fill_done = 1'b1;
               state_nx  = RESP;
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // valid bits: flush clears all, a completed refill sets one
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         valid_q <= '0;
      else if (state == IDLE && flush) valid_q <= '0;
      else if (fill_done)              valid_q[idx_q] <= 1'b1;
   end

   // tag/data store write on refill completion
   always_ff @(posedge clk) begin
      if (fill_done) begin
         tag_mem[idx_q]  <= tag_q;
         data_mem[idx_q] <= mem_rdata;
      end
   end

   // capture request and registered store read; cmp_a/cmp_b hold between lookups
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q   <= '0;
         cmp_a    <= '0;
         cmp_b    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else if (accept) begin
         addr_q   <= req_addr;
         cmp_a    <= tag_mem[req_idx];
         cmp_b    <= req_tag;
         rd_valid <= valid_q[req_idx];
         rd_data  <= data_mem[req_idx];
      end
   end

   // response data/source latch, held until the next response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_data <= '0;
         resp_hit  <= 1'b0;
      end else if (hit) begin
         resp_data <= rd_data;
         resp_hit  <= 1'b1;
      end else if (fill_done) begin
         resp_data <= mem_rdata;
         resp_hit  <= 1'b0;
      end
   end

   // saturating hit/miss statistics, counted at the lookup decision
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == LOOKUP) begin
         if (hit) begin
            if (hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + CNT_W'(1);
         end else begin
            if (miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// tb_cache_tag_ctrl: directed + randomized read traffic against a line-level
// cache model. A second instance with narrow counters shares the stimulus so
// counter saturation is reachable in a short run.
module tb_cache_tag_ctrl;

   localparam int TAG_W = 17, INDEX_W = 5, DATA_W = 32, ADDR_W = 22;

   logic clk = 1'b0;
   logic rst;
   logic req_valid, flush, mem_ack;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] mem_rdata;

   logic req_ready, resp_valid, resp_hit, mem_req, cmp_eq;
   logic [DATA_W-1:0] resp_data;
   logic [TAG_W-1:0]  cmp_a, cmp_b;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       hit_count, miss_count;

   logic s_req_ready, s_resp_valid, s_resp_hit, s_mem_req, s_cmp_eq;
   logic [DATA_W-1:0] s_resp_data;
   logic [TAG_W-1:0]  s_cmp_a, s_cmp_b;
   logic [ADDR_W-1:0] s_mem_addr;
   logic [3:0]        s_hit_count, s_miss_count;

   always #5 clk = ~clk;

   // the equality comparator side unit
   assign cmp_eq   = (cmp_a == cmp_b);
   assign s_cmp_eq = (s_cmp_a == s_cmp_b);

   cache_tag_ctrl u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(req_ready), .flush(flush), .resp_valid(resp_valid),
      .resp_data(resp_data), .resp_hit(resp_hit), .cmp_a(cmp_a), .cmp_b(cmp_b),
      .cmp_eq(cmp_eq), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count));

   cache_tag_ctrl #(.CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(s_req_ready), .flush(flush), .resp_valid(s_resp_valid),
      .resp_data(s_resp_data), .resp_hit(s_resp_hit), .cmp_a(s_cmp_a), .cmp_b(s_cmp_b),
      .cmp_eq(s_cmp_eq), .mem_req(s_mem_req), .mem_addr(s_mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .hit_count(s_hit_count), .miss_count(s_miss_count));

   // ---------------- reference model ----------------
   bit          m_valid [32];
   bit          m_known [32];
   logic [16:0] m_tag   [32];
   logic [31:0] m_data  [32];
   int          m_hits, m_misses;
   logic [16:0] m_last_tag;

   typedef struct {
      bit          hit;
      logic [31:0] data;
      logic [21:0] addr;
      int          hits;
      int          misses;
   } exp_t;
   exp_t q[$];

   logic [31:0] last_data;
   bit          last_hit;
   int n_tests, n_fail;

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // every-cycle comparison of the response side against the model
   always @(negedge clk) begin : cmp_proc
      exp_t e;
      if (!rst) begin
         if (resp_valid) begin
            if (q.size() == 0) chk("resp_without_request", resp_valid, 0);
            else begin
               e = q.pop_front();
               chk("resp_hit", resp_hit, e.hit);
               chk("resp_data", resp_data, e.data);
               chk("resp_mem_addr", mem_addr, e.addr);
               chk("hit_count", hit_count, sat(e.hits, 65535));
               chk("miss_count", miss_count, sat(e.misses, 65535));
               chk("sat_resp_valid", s_resp_valid, 1);
               chk("sat_resp_data", s_resp_data, e.data);
               chk("sat_resp_hit", s_resp_hit, e.hit);
               chk("sat_mem_addr", s_mem_addr, e.addr);
               chk("sat_busy", {s_req_ready, s_mem_req}, 0);
               chk("sat_hit_count", s_hit_count, sat(e.hits, 15));
               chk("sat_miss_count", s_miss_count, sat(e.misses, 15));
               last_data = e.data;
               last_hit  = e.hit;
            end
         end else begin
            chk("resp_data_hold", resp_data, last_data);
            chk("resp_hit_hold", resp_hit, last_hit);
         end
      end
   end

   task automatic wait_ready();
      int guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("req_ready_wait", req_ready, 1);
   endtask

   task automatic accept(input logic [21:0] a);
      wait_ready();
      req_valid = 1'b1;
      req_addr  = a;
      @(posedge clk);
      #1 req_valid = 1'b0;
      m_last_tag = a[21:5];
   endtask

   // one read with the model deciding hit/miss; dly = cycles mem_ack is withheld
   task automatic do_read(input logic [21:0] a, input int dly, input logic [31:0] rd);
      int          idx = int'(a[4:0]);
      logic [16:0] tg  = a[21:5];
      bit          h;
      exp_t        e;
      accept(a);
      h = m_valid[idx] && (m_tag[idx] == tg);
      if (h) m_hits++; else m_misses++;
      e.hit = h; e.data = h ? m_data[idx] : rd; e.addr = a;
      e.hits = m_hits; e.misses = m_misses;
      q.push_back(e);
      @(negedge clk);                       // LOOKUP
      chk("lookup_cmp_b", cmp_b, tg);
      if (m_known[idx]) chk("lookup_cmp_a", cmp_a, m_tag[idx]);
      chk("lookup_no_resp", resp_valid, 0);
      @(negedge clk);                       // T0+2
      if (h) begin
         chk("hit_resp_t2", resp_valid, 1);
         chk("hit_no_mem_req", mem_req, 0);
      end else begin
         chk("miss_mem_req", mem_req, 1);
         chk("miss_mem_addr", mem_addr, a);
         chk("miss_no_resp", resp_valid, 0);
         for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("stall_mem_req", mem_req, 1);
            chk("stall_mem_addr", mem_addr, a);
         end
         mem_ack   = 1'b1;
         mem_rdata = rd;
         @(posedge clk);
         #1 mem_ack = 1'b0;
         mem_rdata  = $urandom;
         m_valid[idx] = 1'b1; m_known[idx] = 1'b1;
         m_tag[idx] = tg;     m_data[idx] = rd;
         @(negedge clk);
         chk("fill_resp_valid", resp_valid, 1);
         chk("fill_mem_req_drop", mem_req, 0);
      end
   endtask

   task automatic do_flush(input logic [21:0] a);
      wait_ready();
      flush = 1'b1; req_valid = 1'b1; req_addr = a;
      #1 chk("flush_req_ready", req_ready, 0);
      @(posedge clk);
      #1 flush = 1'b0; req_valid = 1'b0;
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("flush_not_accepted", cmp_b, m_last_tag);
         chk("flush_idle", {resp_valid, mem_req, req_ready}, 3'b001);
      end
   endtask

   task automatic stray_ack();
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = $urandom;
      @(posedge clk);
      #1 mem_ack = 1'b0;
      @(negedge clk);
      chk("stray_ack_idle", {resp_valid, mem_req, req_ready}, 3'b001);
      chk("stray_ack_cmp_b", cmp_b, m_last_tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, req_ready, 1);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_mem_req"}, mem_req, 0);
      chk({tag, "_resp"}, {resp_data, resp_hit}, 0);
      chk({tag, "_cmp"}, {cmp_a, cmp_b}, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_counts"}, {hit_count, miss_count}, 0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
      m_hits = 0; m_misses = 0; m_last_tag = '0;
      q.delete();
      last_data = '0; last_hit = 1'b0;
   endtask

   // reset asserted mid-refill; no store write may happen
   task automatic reset_in_fill(input logic [21:0] a);
      accept(a);
      @(negedge clk);
      @(negedge clk);
      chk("rstfill_mem_req", mem_req, 1);
      @(negedge clk);
      rst = 1'b1;
      #1 check_reset_outputs("rst_async");
      model_reset();
      mem_ack = 1'b1; mem_rdata = 32'h0BAD0BAD;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; mem_ack = 1'b0;
      chk("rst_held_mem_req", mem_req, 0);
   endtask

   initial begin : watchdog
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : stim
      logic [16:0] tpool [3];
      logic [4:0]  ipool [4];
      logic [21:0] a;
      n_tests = 0; n_fail = 0;
      rst = 1'b1; req_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
      req_addr = '0; mem_rdata = '0;
      for (int i = 0; i < 32; i++) begin
         m_known[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
      end
      model_reset();
      #1 check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // cold miss, then the same address hits
      do_read(22'h2A5A3, 3, 32'hDEADBEEF);
      chk("cold_hit_flag", resp_hit, 0);
      chk("cold_data", resp_data, 32'hDEADBEEF);
      do_read(22'h2A5A3, 3, 32'h12345678);
      chk("warm_hit_flag", resp_hit, 1);
      chk("warm_data", resp_data, 32'hDEADBEEF);
      chk("warm_counts", {hit_count, miss_count}, {16'd1, 16'd1});

      // conflict on index 3: tag 00005 vs tag 1FFFD
      do_read(22'h000A3, 0, 32'hA0A0A0A0);
      do_read(22'h3FFFA3, 1, 32'hB1B1B1B1);
      chk("conflict_miss", resp_hit, 0);
      chk("conflict_cmp_a", cmp_a, 17'h00005);
      chk("conflict_cmp_b", cmp_b, 17'h1FFFD);
      do_read(22'h000A3, 2, 32'hC2C2C2C2);
      chk("evicted_miss", resp_hit, 0);
      chk("evicted_data", resp_data, 32'hC2C2C2C2);

      // flush priority, then previously filled lines miss
      do_flush(22'h000A3);
      do_read(22'h000A3, 0, 32'hD3D3D3D3);
      chk("post_flush_miss", resp_hit, 0);
      do_read(22'h2A5A3, 1, 32'hE4E4E4E4);
      chk("post_flush_miss2", resp_hit, 0);

      // long stall and a stray ack while idle
      do_read(22'h15555, 20, 32'h55AA55AA);
      stray_ack();
      do_read(22'h15555, 0, 32'h0);
      chk("after_stall_hit", resp_hit, 1);

      // reset during refill, then the same address still misses
      reset_in_fill(22'h0ABCD);
      do_read(22'h0ABCD, 1, 32'h77777777);
      chk("post_rst_miss", resp_hit, 0);
      chk("post_rst_counts", {hit_count, miss_count}, {16'd0, 16'd1});

      // randomized traffic over a small address pool
      tpool[0] = 17'h00001; tpool[1] = 17'h1ABCD; tpool[2] = 17'h0F0F0;
      ipool[0] = 5'd1; ipool[1] = 5'd2; ipool[2] = 5'd7; ipool[3] = 5'd31;
      for (int n = 0; n < 250; n++) begin
         a = {tpool[$urandom_range(0, 2)], ipool[$urandom_range(0, 3)]};
         case ($urandom_range(0, 19))
            0:       do_flush(a);
            1:       stray_ack();
            default: do_read(a, $urandom_range(0, 4), $urandom);
         endcase
      end
      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
